regfile_scoreboard: RTL and testbench

Parametrised register file with NUM_RD combinational read ports, one write-back port, and a per-register pending-write scoreboard for pipeline hazard detection. It also has a cycle-by-cycle debug scan port that replaces print-based register tracing. It sits in the decode stage of the core: decode reads operands and busy flags, the issue logic marks destinations pending, and write-back retires them.

---
 rtl/regfile_scoreboard.sv | 99 +++++++++
 tb/tb_regfile_scoreboard.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with write-first bypass and per-register pending-write scoreboard; reads are 0-cycle.
// Debug scan streams one register per cycle for NUM_REGS cycles; there is no backpressure, and dbg_start is ignored mid-scan.
module regfile_scoreboard #(
  parameter  int XLEN     = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  input  logic                   flush,
  input  logic                   dbg_start,
  output logic                   dbg_valid,
  output logic [AW-1:0]          dbg_idx,
  output logic [XLEN-1:0]        dbg_data,
  output logic                   dbg_busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                wb_live;
  state_t              state;
  logic [AW-1:0]       cnt;

  assign wb_live = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Later assignments win: issue beats write-back, flush beats both.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)  busy_nxt[wb_addr] = 1'b0;
    if (iss_en) busy_nxt[iss_rd]  = 1'b1;
    if (flush)  busy_nxt          = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = rs_addr[p*AW +: AW];
    assign hit = wb_live && (wb_addr == a);
    assign rs_data[p*XLEN +: XLEN] = hit ? wb_data : regs[a];
    assign rs_busy[p]              = busy[a] & ~hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (dbg_start) begin
          state <= SCAN;
          cnt   <= '0;
        end
        SCAN: if (cnt == AW'(NUM_REGS - 1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // cnt is held at 0 outside SCAN, so dbg_idx needs no gating.
  assign dbg_valid = (state == SCAN);
  assign dbg_idx   = cnt;
  assign dbg_data  = dbg_valid ? regs[cnt] : '0;
  assign dbg_busy  = dbg_valid & busy[cnt];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, scoreboard priority, flush, debug scan and reset abort.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        dbg_start;
  logic        dbg_valid;
  logic [4:0]  dbg_idx;
  logic [31:0] dbg_data;
  logic        dbg_busy;

  int n_chk = 0;
  int n_err = 0;

  regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) dut (
    .clk(clk), .rst(rst),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush),
    .dbg_start(dbg_start), .dbg_valid(dbg_valid), .dbg_idx(dbg_idx),
    .dbg_data(dbg_data), .dbg_busy(dbg_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rs_addr = {a1, a0};
  endtask

  logic [31:0] exp_d;

  initial begin
    rst = 1'b1; rs_addr = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    iss_en = 1'b0; iss_rd = '0; flush = 1'b0; dbg_start = 1'b0;
    #2;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      #1;
      chk("rst_data0", rs_data[31:0], 32'h0);
      chk("rst_data1", rs_data[63:32], 32'h0);
      chk("rst_busy", 32'(rs_busy), 32'h0);
    end
    chk("rst_dbg_valid", 32'(dbg_valid), 32'h0);
    chk("rst_dbg_idx", 32'(dbg_idx), 32'h0);
    chk("rst_dbg_data", dbg_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Writes to register 0 are dropped, including through the bypass.
    tick; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; rd(5'd0, 5'd0);
    #1 chk("r0_bypass", rs_data[31:0], 32'h0);
    tick; wb_en = 1'b0;
    #1 chk("r0_read", rs_data[31:0], 32'h0);

    tick; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; rd(5'd5, 5'd5);
    #1 chk("r5_bypass0", rs_data[31:0], 32'hDEAD_BEEF);
    chk("r5_bypass1", rs_data[63:32], 32'hDEAD_BEEF);
    chk("r5_busy", 32'(rs_busy[0]), 32'h0);
    tick; wb_en = 1'b0;
    #1 chk("r5_read", rs_data[31:0], 32'hDEAD_BEEF);

    // Issue vs write-back on the same register.
    tick; iss_en = 1'b1; iss_rd = 5'd7; rd(5'd7, 5'd5);
    #1 chk("r7_busy_pre", 32'(rs_busy[0]), 32'h0);
    tick; iss_en = 1'b0;
    #1 chk("r7_busy_set", 32'(rs_busy[0]), 32'h1);
    chk("r5_not_busy", 32'(rs_busy[1]), 32'h0);
    tick; iss_en = 1'b1; iss_rd = 5'd7; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h11;
    #1 chk("r7_same_wb_busy", 32'(rs_busy[0]), 32'h0);
    chk("r7_same_wb_data", rs_data[31:0], 32'h11);
    tick; iss_en = 1'b0; wb_en = 1'b0;
    #1 chk("r7_reissue_busy", 32'(rs_busy[0]), 32'h1);
    chk("r7_data", rs_data[31:0], 32'h11);
    tick; wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12;
    tick; wb_en = 1'b0;
    #1 chk("r7_wb_clear", 32'(rs_busy[0]), 32'h0);
    chk("r7_data2", rs_data[31:0], 32'h12);

    // Flush with a concurrent write-back.
    tick; iss_en = 1'b1; iss_rd = 5'd3; rd(5'd3, 5'd4);
    tick; iss_rd = 5'd4;
    #1 chk("r3_busy", 32'(rs_busy[0]), 32'h1);
    tick; iss_en = 1'b0; flush = 1'b1; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h22;
    #1 chk("flush_cyc_busy3", 32'(rs_busy[0]), 32'h0);
    chk("flush_cyc_busy4", 32'(rs_busy[1]), 32'h1);
    tick; flush = 1'b0; wb_en = 1'b0;
    #1 chk("flush_busy", 32'(rs_busy), 32'h0);
    chk("flush_r3_data", rs_data[31:0], 32'h22);
    tick; iss_en = 1'b1; iss_rd = 5'd0; rd(5'd0, 5'd0);
    tick; iss_en = 1'b0;
    #1 chk("r0_never_busy", 32'(rs_busy), 32'h0);

    // Preload regs[i] = 3*i, mark r9 pending, then scan.
    for (int i = 1; i < 32; i++) begin
      tick; wb_en = 1'b1; wb_addr = 5'(i); wb_data = 32'(3 * i);
    end
    tick; wb_en = 1'b0; dbg_start = 1'b1; iss_en = 1'b1; iss_rd = 5'd9;
    #1 chk("idle_valid", 32'(dbg_valid), 32'h0);
    tick; dbg_start = 1'b0; iss_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 2) begin wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h777; end
      if (k == 3) wb_en = 1'b0;
      if (k == 5) dbg_start = 1'b1;
      if (k == 6) dbg_start = 1'b0;
      #1;
      exp_d = (k == 20) ? 32'h777 : 32'(3 * k);
      chk("scan_valid", 32'(dbg_valid), 32'h1);
      chk("scan_idx", 32'(dbg_idx), 32'(k));
      chk("scan_data", dbg_data, exp_d);
      chk("scan_busy", 32'(dbg_busy), (k == 9) ? 32'h1 : 32'h0);
      tick;
    end
    #1 chk("scan_end_valid", 32'(dbg_valid), 32'h0);
    chk("scan_end_idx", 32'(dbg_idx), 32'h0);
    chk("scan_end_data", dbg_data, 32'h0);

    // Reset aborts a scan in progress.
    tick; dbg_start = 1'b1;
    tick; dbg_start = 1'b0;
    repeat (10) tick;
    #1 chk("abort_idx10", 32'(dbg_idx), 32'd10);
    chk("abort_pre_valid", 32'(dbg_valid), 32'h1);
    rst = 1'b1; rd(5'd5, 5'd20);
    #1 chk("abort_valid", 32'(dbg_valid), 32'h0);
    chk("abort_idx", 32'(dbg_idx), 32'h0);
    chk("abort_r5", rs_data[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    #1 chk("post_rst_r5", rs_data[31:0], 32'h0);
    chk("post_rst_r20", rs_data[63:32], 32'h0);
    chk("post_rst_valid", 32'(dbg_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
